// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the Pmod display output stage:
//   - sync_pol_e    : active level of a sync signal
//   - timing_t      : bundle of the four timing strobes (hs, vs, de, frame)
//   - BAYER_THRESH  : 2x2 ordered-dither threshold table, indexed by
//                     {x[0] ^ parity, y[0]}
//   - bayer_index() : forms that index from the aligned-domain counters
//   - idle_timing() : the inactive (reset) value of a timing bundle
// -----------------------------------------------------------------------------
package display_pkg;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic frame;
  } timing_t;

  localparam logic [1:0] BAYER_THRESH [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

  // Only bit 0 of each counter selects the Bayer cell; the upper bits exist
  // so the counters wrap over a 4x4 neighbourhood.
  function automatic logic [1:0] bayer_index(input logic [1:0] x,
                                             input logic [1:0] y,
                                             input logic       parity);
    return {x[0] ^ parity, y[0]};
  endfunction

  function automatic timing_t idle_timing(input sync_pol_e h_pol,
                                          input sync_pol_e v_pol);
    timing_t t;
    t.hs    = (h_pol == SYNC_ACTIVE_LOW);
    t.vs    = (v_pol == SYNC_ACTIVE_LOW);
    t.de    = 1'b0;
    t.frame = 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/display_pmod_out_if.sv
// -----------------------------------------------------------------------------
// display_pmod_out_if
// Pixel-source bundle feeding the Pmod output stage.
//   hs, vs, de, frame : timing strobes from the display timing generator
//   r, g, b           : IN_BITS colour, valid SRC_LAT cycles after its timing
// Modports: master = pixel source (drives), slave = output stage (receives).
// -----------------------------------------------------------------------------
interface display_pmod_out_if #(
  parameter int IN_BITS = 8
);
  logic               hs;
  logic               vs;
  logic               de;
  logic               frame;
  logic [IN_BITS-1:0] r;
  logic [IN_BITS-1:0] g;
  logic [IN_BITS-1:0] b;

  modport master (output hs, vs, de, frame, r, g, b);
  modport slave  (input  hs, vs, de, frame, r, g, b);
endinterface

// File: rtl/display_delay.sv
// -----------------------------------------------------------------------------
// display_delay
// Fixed-depth shift register with asynchronous active-low reset.
//   WIDTH   : data width
//   DEPTH   : number of register stages (0 = combinational bypass)
//   RST_VAL : value loaded into every stage while reset is asserted
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : data entering stage 0
//   out_data   : data leaving the last stage, DEPTH cycles later
// -----------------------------------------------------------------------------
module display_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_bypass
    assign out_data = in_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      // NOTE: every element is assigned on every pass, so no latch can form.
      stage_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: all stages are reset (not just the last) so that a release
        // mid-frame emits only inactive timing until real samples arrive.
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        // NOTE: non-blocking so every stage samples its neighbour's old value.
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign out_data = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/display_pmod_out_core.sv
// -----------------------------------------------------------------------------
// display_pmod_out_core
// Aligns timing to the delayed pixel stream, blanks and quantises colour, and
// registers everything on the way out.
//   Timing path : SRC_LAT-stage delay + output register (SRC_LAT+1 cycles)
//   Colour path : output register only (1 cycle)
// Optional feature macro DISPLAY_PMOD_DITHER_EN: adds 2-bit x/y counters and a
// frame parity bit in the aligned domain and applies 2x2 ordered dither before
// truncation; otherwise colour is simply truncated.
// Ports:
//   clk, rst_n            : pixel clock, asynchronous active-low reset
//   pix (slave)           : timing + IN_BITS colour from the pixel source
//   o_hs/o_vs/o_de/o_frame: aligned registered timing
//   o_r/o_g/o_b           : registered, blanked, quantised OUT_BITS colour
// -----------------------------------------------------------------------------
module display_pmod_out_core
  import display_pkg::*;
#(
  parameter int        IN_BITS  = 8,
  parameter int        OUT_BITS = 4,
  parameter int        SRC_LAT  = 1,
  parameter sync_pol_e H_POL    = SYNC_ACTIVE_LOW,
  parameter sync_pol_e V_POL    = SYNC_ACTIVE_LOW
) (
  input  logic                clk,
  input  logic                rst_n,
  display_pmod_out_if.slave   pix,
  output logic                o_hs,
  output logic                o_vs,
  output logic                o_de,
  output logic                o_frame,
  output logic [OUT_BITS-1:0] o_r,
  output logic [OUT_BITS-1:0] o_g,
  output logic [OUT_BITS-1:0] o_b
);

  localparam int      D        = IN_BITS - OUT_BITS;
  localparam int      SHIFT    = (D >= 2) ? D - 2 : 0;
  localparam timing_t TIM_IDLE = idle_timing(H_POL, V_POL);

  timing_t             tim_in;
  timing_t             tim_al;   // timing aligned with the current pixel
  timing_t             tim_d;
  timing_t             tim_q;
  logic [OUT_BITS-1:0] r_d, g_d, b_d;
  logic [OUT_BITS-1:0] r_q, g_q, b_q;
  logic [1:0]          thresh;

  assign tim_in = {pix.hs, pix.vs, pix.de, pix.frame};

  display_delay #(
    .WIDTH   ($bits(timing_t)),
    .DEPTH   (SRC_LAT),
    .RST_VAL (TIM_IDLE)
  ) u_tim_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (tim_in),
    .out_data (tim_al)
  );

`ifdef DISPLAY_PMOD_DITHER_EN
  // Dither needs at least two discarded bits to hold a 2-bit threshold.
  localparam bit DITHER = (D >= 2);

  logic [1:0] x_q, x_d;
  logic [1:0] y_q, y_d;
  logic       parity_q, parity_d;
  logic       de_prev_q, de_prev_d;

  always_comb begin
    x_d       = tim_al.de ? x_q + 2'd1 : 2'd0;
    y_d       = y_q;
    // Frame start wins over a line end landing on the same cycle.
    if (tim_al.frame) begin
      y_d = 2'd0;
    end else if (de_prev_q && !tim_al.de) begin
      y_d = y_q + 2'd1;
    end
    parity_d  = parity_q ^ tim_al.frame;
    de_prev_d = tim_al.de;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= 2'd0;
      y_q       <= 2'd0;
      parity_q  <= 1'b0;
      de_prev_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      parity_q  <= parity_d;
      de_prev_q <= de_prev_d;
    end
  end

  // Parity flips the pattern horizontally every other frame so the dither
  // texture does not sit still on static content.
  assign thresh = BAYER_THRESH[bayer_index(x_q, y_q, parity_q)];
`else
  localparam bit DITHER = 1'b0;

  assign thresh = 2'd0;
`endif

  // Add the scaled threshold one bit wider than the input so a carry out can
  // be detected and clamped instead of wrapping bright pixels to black.
  function automatic logic [OUT_BITS-1:0] quantise(input logic [IN_BITS-1:0] c,
                                                   input logic [1:0]         thr);
    logic [IN_BITS:0] sum;
    sum = {1'b0, c} + ((IN_BITS+1)'(thr) << SHIFT);
    if (!DITHER) begin
      return c[IN_BITS-1:D];
    end
    if (sum[IN_BITS]) begin
      return '1;
    end
    return sum[IN_BITS-1:D];
  endfunction

  always_comb begin
    tim_d = tim_al;
    r_d   = '0;
    g_d   = '0;
    b_d   = '0;
    if (tim_al.de) begin
      r_d = quantise(pix.r, thresh);
      g_d = quantise(pix.g, thresh);
      b_d = quantise(pix.b, thresh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim_q <= TIM_IDLE;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      tim_q <= tim_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
    end
  end

  assign o_hs    = tim_q.hs;
  assign o_vs    = tim_q.vs;
  assign o_de    = tim_q.de;
  assign o_frame = tim_q.frame;
  assign o_r     = r_q;
  assign o_g     = g_q;
  assign o_b     = b_q;

endmodule

// File: rtl/display_pmod_out.sv
// -----------------------------------------------------------------------------
// display_pmod_out
// Top level of the Pmod display output stage: aligns timing from the display
// timing generator with the pixel source (SRC_LAT cycles behind), blanks colour
// outside DE, reduces IN_BITS to OUT_BITS per channel and registers all pins.
// Optional feature macro DISPLAY_PMOD_DITHER_EN enables 2x2 ordered dither with
// per-frame pattern flip; without it colour is truncated.
// Parameters: IN_BITS (1..8), OUT_BITS (1..IN_BITS), SRC_LAT (0..15),
//             H_POL / V_POL (active sync levels).
// Ports:
//   i_pixclk, i_rst_n            : pixel clock, asynchronous active-low reset
//   i_hs, i_vs, i_de, i_frame    : timing inputs
//   i_r, i_g, i_b                : IN_BITS colour, SRC_LAT cycles after timing
//   o_hs, o_vs, o_de, o_frame    : timing, SRC_LAT+1 cycles after input
//   o_r, o_g, o_b                : OUT_BITS colour, 1 cycle after input
// -----------------------------------------------------------------------------
module display_pmod_out
  import display_pkg::*;
#(
  parameter int        IN_BITS  = 8,
  parameter int        OUT_BITS = 4,
  parameter int        SRC_LAT  = 1,
  parameter sync_pol_e H_POL    = SYNC_ACTIVE_LOW,
  parameter sync_pol_e V_POL    = SYNC_ACTIVE_LOW
) (
  input  logic                i_pixclk,
  input  logic                i_rst_n,
  input  logic                i_hs,
  input  logic                i_vs,
  input  logic                i_de,
  input  logic                i_frame,
  input  logic [IN_BITS-1:0]  i_r,
  input  logic [IN_BITS-1:0]  i_g,
  input  logic [IN_BITS-1:0]  i_b,
  output logic                o_hs,
  output logic                o_vs,
  output logic                o_de,
  output logic                o_frame,
  output logic [OUT_BITS-1:0] o_r,
  output logic [OUT_BITS-1:0] o_g,
  output logic [OUT_BITS-1:0] o_b
);

  if (IN_BITS < 1 || IN_BITS > 8) begin : g_bad_in_bits
    $error("display_pmod_out: IN_BITS must be in 1..8");
  end
  if (OUT_BITS < 1 || OUT_BITS > IN_BITS) begin : g_bad_out_bits
    $error("display_pmod_out: OUT_BITS must be in 1..IN_BITS");
  end
  if (SRC_LAT < 0 || SRC_LAT > 15) begin : g_bad_src_lat
    $error("display_pmod_out: SRC_LAT must be in 0..15");
  end

  display_pmod_out_if #(.IN_BITS(IN_BITS)) u_pix ();

  assign u_pix.hs    = i_hs;
  assign u_pix.vs    = i_vs;
  assign u_pix.de    = i_de;
  assign u_pix.frame = i_frame;
  assign u_pix.r     = i_r;
  assign u_pix.g     = i_g;
  assign u_pix.b     = i_b;

  display_pmod_out_core #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .SRC_LAT  (SRC_LAT),
    .H_POL    (H_POL),
    .V_POL    (V_POL)
  ) u_core (
    .clk     (i_pixclk),
    .rst_n   (i_rst_n),
    .pix     (u_pix.slave),
    .o_hs    (o_hs),
    .o_vs    (o_vs),
    .o_de    (o_de),
    .o_frame (o_frame),
    .o_r     (o_r),
    .o_g     (o_g),
    .o_b     (o_b)
  );

endmodule

// File: tb/tb_display_pmod_out.sv
// -----------------------------------------------------------------------------
// tb_display_pmod_out
// Scoreboard bench for display_pmod_out (SRC_LAT=3, hsync active-high, vsync
// active-low). Stimulus pushes the expected registered output per cycle; a
// monitor pops and compares one cycle-image per clock. The reference model
// works from whole-stream quantities: timing seen SRC_LAT cycles ago, length of
// the current DE run, DE-low transitions since the last frame pulse and the
// number of frame pulses.
// -----------------------------------------------------------------------------
module tb_display_pmod_out;
  import display_pkg::*;

  localparam int        IN_BITS  = 8;
  localparam int        OUT_BITS = 4;
  localparam int        SRC_LAT  = 3;
  localparam sync_pol_e H_POL    = SYNC_ACTIVE_HIGH;
  localparam sync_pol_e V_POL    = SYNC_ACTIVE_LOW;
  localparam logic      HS_ACT   = 1'b1;
  localparam logic      VS_ACT   = 1'b0;
  localparam int        D        = IN_BITS - OUT_BITS;
`ifdef DISPLAY_PMOD_DITHER_EN
  localparam int        BAYER_TB [4] = '{0, 2, 3, 1};
`endif

  typedef struct packed { logic hs; logic vs; logic de; logic frame; } tim_t;
  typedef struct packed { tim_t t; logic [IN_BITS-1:0]  r, g, b; } vec_t;
  typedef struct packed { tim_t t; logic [OUT_BITS-1:0] r, g, b; } out_t;

  localparam tim_t TIM_IDLE = '{hs: ~HS_ACT, vs: ~VS_ACT, de: 1'b0, frame: 1'b0};
  localparam out_t OUT_IDLE = '{t: TIM_IDLE, r: '0, g: '0, b: '0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  display_pmod_out_if #(.IN_BITS(IN_BITS)) drv ();

  logic                o_hs, o_vs, o_de, o_frame;
  logic [OUT_BITS-1:0] o_r, o_g, o_b;

  display_pmod_out #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .SRC_LAT  (SRC_LAT),
    .H_POL    (H_POL),
    .V_POL    (V_POL)
  ) dut (
    .i_pixclk (clk),
    .i_rst_n  (rst_n),
    .i_hs     (drv.hs),
    .i_vs     (drv.vs),
    .i_de     (drv.de),
    .i_frame  (drv.frame),
    .i_r      (drv.r),
    .i_g      (drv.g),
    .i_b      (drv.b),
    .o_hs     (o_hs),
    .o_vs     (o_vs),
    .o_de     (o_de),
    .o_frame  (o_frame),
    .o_r      (o_r),
    .o_g      (o_g),
    .o_b      (o_b)
  );

  // Scoreboard and counters
  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  tim_t hist[$];
  int   run_len;
  int   lines;
  int   frames;
  bit   prev_de;

  function automatic out_t sample();
    out_t s;
    s.t = '{hs: o_hs, vs: o_vs, de: o_de, frame: o_frame};
    s.r = o_r;
    s.g = o_g;
    s.b = o_b;
    return s;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got hs=%b vs=%b de=%b fr=%b rgb=%h/%h/%h, expected hs=%b vs=%b de=%b fr=%b rgb=%h/%h/%h",
               name, $time, got.t.hs, got.t.vs, got.t.de, got.t.frame, got.r, got.g, got.b,
               exp.t.hs, exp.t.vs, exp.t.de, exp.t.frame, exp.r, exp.g, exp.b);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  function automatic logic [OUT_BITS-1:0] model_colour(input int c, input int xp,
                                                       input int yp, input int par);
`ifdef DISPLAY_PMOD_DITHER_EN
    if (D >= 2) begin
      int v;
      v = c + BAYER_TB[((xp % 2) ^ par) * 2 + (yp % 2)] * (1 << (D - 2));
      if (v > (1 << IN_BITS) - 1) return OUT_BITS'((1 << OUT_BITS) - 1);
      return OUT_BITS'(v >> D);
    end
`endif
    return OUT_BITS'(c >> D);
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < SRC_LAT; i++) hist.push_back(TIM_IDLE);
    run_len = 0;
    lines   = 0;
    frames  = 0;
    prev_de = 1'b0;
  endfunction

  // Apply one input vector for one clock and queue the output it must produce.
  task automatic cycle(input vec_t v, input logic rst_val);
    out_t e;
    tim_t a;
    @(negedge clk);
    rst_n     = rst_val;
    drv.hs    = v.t.hs;
    drv.vs    = v.t.vs;
    drv.de    = v.t.de;
    drv.frame = v.t.frame;
    drv.r     = v.r;
    drv.g     = v.g;
    drv.b     = v.b;
    if (!rst_val) begin
      model_reset();
      e = OUT_IDLE;
    end else begin
      if (SRC_LAT == 0) begin
        a = v.t;
      end else begin
        a = hist.pop_front();
        hist.push_back(v.t);
      end
      e   = '{t: a, r: '0, g: '0, b: '0};
      if (a.de) begin
        e.r = model_colour(int'(v.r), run_len, lines, frames % 2);
        e.g = model_colour(int'(v.g), run_len, lines, frames % 2);
        e.b = model_colour(int'(v.b), run_len, lines, frames % 2);
      end
      run_len = a.de ? run_len + 1 : 0;
      if (a.frame) lines = 0;
      else if (prev_de && !a.de) lines++;
      if (a.frame) frames++;
      prev_de = a.de;
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [IN_BITS-1:0] col(input int fixed);
    if (fixed < 0) return IN_BITS'($urandom_range(0, (1 << IN_BITS) - 1));
    return IN_BITS'(fixed);
  endfunction

  function automatic vec_t mk(input logic hs, input logic vs, input logic de,
                              input logic fr, input int fixed);
    vec_t v;
    v.t = '{hs: hs, vs: vs, de: de, frame: fr};
    v.r = col(fixed);
    v.g = col(fixed);
    v.b = col(fixed);
    return v;
  endfunction

  // Blanking colour is forced bright so any leak through DE blanking shows.
  task automatic gen_line(input int run, input int fixed);
    repeat (2) cycle(mk(HS_ACT, ~VS_ACT, 1'b0, 1'b0, 'hFF), 1'b1);
    cycle(mk(~HS_ACT, ~VS_ACT, 1'b0, 1'b0, -1), 1'b1);
    for (int i = 0; i < run; i++) cycle(mk(~HS_ACT, ~VS_ACT, 1'b1, 1'b0, fixed), 1'b1);
    cycle(mk(~HS_ACT, ~VS_ACT, 1'b0, 1'b0, 'hFF), 1'b1);
  endtask

  task automatic gen_frame(input int n_lines, input int run, input int fixed);
    cycle(mk(~HS_ACT, VS_ACT, 1'b0, 1'b1, 'hFF), 1'b1);
    cycle(mk(~HS_ACT, VS_ACT, 1'b0, 1'b0, 'hFF), 1'b1);
    for (int l = 0; l < n_lines; l++) begin
      gen_line((run <= 0) ? int'($urandom_range(1, 9)) : run, fixed);
    end
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", sample(), OUT_IDLE);
  endtask

  // Monitor: compares one queued expectation per clock, away from the edge.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out", sample(), e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    drv.hs    = ~HS_ACT;
    drv.vs    = ~VS_ACT;
    drv.de    = 1'b0;
    drv.frame = 1'b0;
    drv.r     = '0;
    drv.g     = '0;
    drv.b     = '0;
    model_reset();

    repeat (4) cycle(mk(~HS_ACT, ~VS_ACT, 1'b0, 1'b0, 0), 1'b0);
    repeat (2) cycle(mk(~HS_ACT, ~VS_ACT, 1'b0, 1'b0, 0), 1'b1);

    // Single DE pulse; its colour follows SRC_LAT cycles later.
    cycle(mk(~HS_ACT, ~VS_ACT, 1'b1, 1'b0, 'hFF), 1'b1);
    repeat (SRC_LAT - 1) cycle(mk(~HS_ACT, ~VS_ACT, 1'b0, 1'b0, 'hFF), 1'b1);
    cycle(mk(~HS_ACT, ~VS_ACT, 1'b0, 1'b0, 'h5A), 1'b1);
    repeat (4) cycle(mk(~HS_ACT, ~VS_ACT, 1'b0, 1'b0, 0), 1'b1);

    // Flat fields over 2x2 blocks in consecutive frames, then saturation.
    gen_frame(2, 4, 'h88);
    gen_frame(2, 4, 'h88);
    gen_frame(2, 4, 'hFF);
    gen_frame(2, 4, 'h8F);
    gen_frame(3, 5, 'h8F);

    // Bright colour held during blanking while syncs toggle.
    for (int i = 0; i < 12; i++) begin
      cycle(mk((i % 3 == 0) ? HS_ACT : ~HS_ACT, (i % 5 == 0) ? VS_ACT : ~VS_ACT,
               1'b0, 1'b0, 'hFF), 1'b1);
    end

    // Randomised frames.
    repeat (4) gen_frame(int'($urandom_range(2, 5)), 0, -1);

    // Reset asserted mid-line, released while the line is still active.
    cycle(mk(~HS_ACT, VS_ACT, 1'b0, 1'b1, 'hFF), 1'b1);
    repeat (2) cycle(mk(HS_ACT, ~VS_ACT, 1'b0, 1'b0, 'hFF), 1'b1);
    repeat (5) cycle(mk(~HS_ACT, ~VS_ACT, 1'b1, 1'b0, -1), 1'b1);
    async_reset_check();
    repeat (3) cycle(mk(~HS_ACT, ~VS_ACT, 1'b1, 1'b0, -1), 1'b0);
    repeat (6) cycle(mk(~HS_ACT, ~VS_ACT, 1'b1, 1'b0, -1), 1'b1);
    cycle(mk(~HS_ACT, ~VS_ACT, 1'b0, 1'b0, 'hFF), 1'b1);
    gen_frame(3, 0, -1);

    repeat (SRC_LAT + 3) cycle(mk(~HS_ACT, ~VS_ACT, 1'b0, 1'b0, 0), 1'b1);
    repeat (3) @(posedge clk);
    #2;
    check_int("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
